aes_word_packer: RTL and testbench
==================================

Name: aes_word_packer

Overview:
Input stage of the AES datapath. Collects 32-bit words from the host/bus interface into a 128-bit plaintext block. Presents the block through a valid/ready handshake to the 128-bit state register feeding round 0. Double-buffered (assembly buffer plus output register), so a new block can be assembled while the previous one waits for the core.

Parameters:
WORD_W, 32, input word width; fixed at 32, other values unsupported.
BLOCK_W, 128, output block width; fixed at 128 (AES state size).
WORDS, 4, words per block (BLOCK_W/WORD_W); derived, not overridden.

Ports:
clk  input  1  rising-edge clock; only clock of the block.
rstn  input  1  reset, asynchronous assert, active-low.
flush  input  1  sync clear of partially assembled block; output register untouched.
in_valid  input  1  in_data holds a valid word.
in_ready  output  1  block can accept a word this cycle.
in_data  input  32  input word; first word of a block is state bytes 0..3.
out_valid  output  1  out_data holds a complete block.
out_ready  input  1  downstream accepts block this cycle.
out_data  output  128  assembled block; byte 0 at [127:120].
word_cnt  output  2  words held in assembly buffer (0..3).

Behaviour:
- Reset (rstn=0, async): word_cnt=0, out_valid=0, out_data=0, assembly buffer=0. in_ready=1 combinationally once out of reset.
- Word accept: in_valid && in_ready at a rising edge.
- Word k (k = word_cnt, 0..2) is stored in assembly slot k. word_cnt increments.
- Fourth word (word_cnt==3):
  - out_data <= {slot0, slot1, slot2, in_data} (slot0 in [127:96], in_data in [31:0]).
  - out_valid <= 1, word_cnt <= 0.
- in_ready = !flush && (word_cnt!=3 || !out_valid || out_ready). Combinational; no dependency on in_valid.
- Block accept: out_valid && out_ready at an edge. out_valid <= 0 unless a fourth word completes in the same cycle; in that case out_valid stays 1 and out_data takes the new block.
- Latency: out_valid rises the cycle after the 4th word is accepted. Sustained throughput is 1 word/cycle when out_ready is held high (one block every 4 cycles, no bubbles).
- Backpressure:
  - With out_valid=1 and out_ready=0, the words of the next block are still accepted until word_cnt==3.
  - After that, in_ready=0 until the output drains.
  - out_data is stable while out_valid && !out_ready.
- flush=1:
  - word_cnt <= 0, assembly buffer contents ignored thereafter.
  - in_ready=0, so no word is accepted that cycle.
  - out_valid/out_data unaffected; a block already in the output register is still delivered.
- Simultaneous flush and out_ready: the output handshake completes normally.
- Reset mid-block: partial words and any pending output are discarded; no output beat is generated.
- No arithmetic; all counters wrap only via explicit clear at 3 (no wrap to 0 by overflow).
- FSM is implicit in word_cnt (FILL0..FILL3) plus out_valid (EMPTY/FULL). No other states.

Optional Feature:
AES_PACKER_BYTESWAP_EN:
- Defined: each in_data word is byte-reversed before storage ({in_data[7:0], in_data[15:8], in_data[23:16], in_data[31:24]}), for little-endian bus masters.
- Not defined: words are stored as received.
- Handshake and timing are identical in both builds.

Decomposition:
- Shared package aes_pkg:
  - AES_BLOCK_W=128, AES_WORD_W=32, AES_WORDS=4.
  - typedef for the 128-bit state and the 32-bit word.
  - byte-reverse function, reused by the output-side unpacker.
- No sub-module. The block is one counter, a 96-bit buffer and a 128-bit output register; splitting it adds nothing.

Test Plan:
- FIPS-197 plaintext, back-to-back: words 00112233, 44556677, 8899aabb, ccddeeff with out_ready=1 -> out_valid one cycle after 4th accept, out_data=00112233445566778899aabbccddeeff, word_cnt returns to 0.
- Backpressure: out_ready=0, feed 8 words continuously -> first block held stable; words 5-7 accepted (word_cnt=3); in_ready=0 on word 8. Raise out_ready -> block 1 taken, word 8 accepted the same cycle, block 2 appears next cycle.
- Flush: accept 0xAAAAAAAA, 0xBBBBBBBB, pulse flush with in_valid=1 -> in_ready=0 that cycle, word_cnt=0. Then feed 4 words of 0x11111111 -> out_data=0x1111...1111.
- Async reset mid-block: assert rstn=0 between clock edges after 2 words with a block pending -> out_valid=0 and word_cnt=0 immediately, without waiting for a clock edge. Post-reset block assembles cleanly.
- Random valid/ready throttling, 1000 blocks -> scoreboard matches every block in order, no drop or duplicate.
- With AES_PACKER_BYTESWAP_EN: words 33221100, 77665544, bbaa9988, ffeeddcc -> out_data=00112233445566778899aabbccddeeff.

Source files
------------

// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the AES datapath: block/word geometry, the state
// and word types, the word-assembly fill states, and a byte-reverse helper
// used by both the input packer and the output-side unpacker.
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_WORD_W  = 32;
    localparam int AES_WORDS   = AES_BLOCK_W / AES_WORD_W;

    typedef logic [AES_BLOCK_W-1:0] aes_state_t;
    typedef logic [AES_WORD_W-1:0]  aes_word_t;

    // Number of words already held in the assembly buffer.
    typedef enum logic [1:0] {
        FILL0 = 2'd0,
        FILL1 = 2'd1,
        FILL2 = 2'd2,
        FILL3 = 2'd3
    } fill_t;

    // Reverse the byte order of a word (little-endian bus <-> AES byte order).
    function automatic aes_word_t aes_byte_rev(input aes_word_t w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_word_packer.sv
// ---------------------------------------------------------------------------
// aes_word_packer
// Input stage of the AES datapath. Collects four 32-bit words into a 128-bit
// plaintext block and hands it to the round-0 state register through a
// valid/ready handshake. Double-buffered: a 96-bit assembly buffer plus a
// 128-bit output register, so the next block fills while the previous one
// waits for the core.
//
// Ports:
//   clk        rising-edge clock
//   rstn       asynchronous active-low reset
//   flush      synchronous clear of the partially assembled block
//   in_valid   in_data holds a valid word
//   in_ready   a word can be accepted this cycle (combinational)
//   in_data    input word; first word of a block is state bytes 0..3
//   out_valid  out_data holds a complete block
//   out_ready  downstream accepts the block this cycle
//   out_data   assembled block, byte 0 at [127:120]
//   word_cnt   words held in the assembly buffer (0..3)
//
// Build option:
//   AES_PACKER_BYTESWAP_EN  byte-reverse every incoming word before storage
//                           (little-endian bus masters). Timing unchanged.
//
// State table (fill state == word_cnt; out_valid is the EMPTY/FULL flag)
//   state | meaning
//   FILL0 | no words buffered, next word goes to slot 0
//   FILL1 | slot 0 valid
//   FILL2 | slots 0..1 valid
//   FILL3 | slots 0..2 valid, next accepted word completes the block
// ---------------------------------------------------------------------------
module aes_word_packer
    import aes_pkg::*;
#(
    parameter int WORD_W  = AES_WORD_W,
    parameter int BLOCK_W = AES_BLOCK_W
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WORD_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_data,
    output logic [1:0]         word_cnt
);

    localparam int WORDS = BLOCK_W / WORD_W;

    fill_t             state;
    fill_t             state_nxt;
    logic              accept;
    logic              last_word;
    logic [WORD_W-1:0] word_in;
    logic [WORD_W-1:0] slot [0:WORDS-2];

`ifdef AES_PACKER_BYTESWAP_EN
    assign word_in = aes_byte_rev(in_data);
`else
    assign word_in = in_data;
`endif

    // The fourth word may only enter when the output register is free or is
    // being emptied in this same cycle.
    assign in_ready  = !flush && ((state != FILL3) || !out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign last_word = accept && (state == FILL3);
    assign word_cnt  = state;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= FILL0;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = FILL0;
        end else if (accept) begin
            case (state)
                FILL0:   state_nxt = FILL1;
                FILL1:   state_nxt = FILL2;
                FILL2:   state_nxt = FILL3;
                FILL3:   state_nxt = FILL0;
                default: state_nxt = FILL0;
            endcase
        end
    end

    // Assembly buffer: stale contents after a flush are simply overwritten.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            slot <= '{default: '0};
        end else if (accept) begin
            case (state)
                FILL0:   slot[0] <= word_in;
                FILL1:   slot[1] <= word_in;
                FILL2:   slot[2] <= word_in;
                default: ;
            endcase
        end
    end

    // Output register: a completing block wins over a same-cycle drain, so
    // out_valid stays high and out_data takes the new block.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (last_word) begin
            out_valid <= 1'b1;
            out_data  <= {slot[0], slot[1], slot[2], word_in};
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_aes_word_packer.sv
module tb_aes_word_packer;

    logic         clk = 1'b0;
    logic         rstn;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [1:0]   word_cnt;

    aes_word_packer dut (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .word_cnt  (word_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: words accepted so far for the current block, the
    // block held for the core, and the in-order scoreboard of blocks owed.
    logic [31:0]  asm_w [$];
    bit           full;
    logic [127:0] held;
    logic [127:0] exp_q [$];
    int           nblk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] stored(input logic [31:0] w);
`ifdef AES_PACKER_BYTESWAP_EN
        return {<<8{w}};
`else
        return w;
`endif
    endfunction

    // Word as the bus must present it so that AES byte order w results.
    function automatic logic [31:0] bus_word(input logic [31:0] w);
        return stored(w);
    endfunction

    task automatic model_reset();
        asm_w.delete();
        exp_q.delete();
        full = 0;
        held = '0;
    endtask

    // Checks DUT against the model just before the rising edge, then
    // advances the model by that edge.
    task automatic model_step(output bit acc);
        bit exp_ready;
        bit take;
        exp_ready = !flush && (asm_w.size() != 3 || !full || out_ready);
        chk("in_ready", {127'd0, in_ready}, {127'd0, exp_ready});
        chk("word_cnt", {126'd0, word_cnt}, 128'(asm_w.size()));
        chk("out_valid", {127'd0, out_valid}, {127'd0, full});
        if (full) chk("out_data", out_data, held);
        acc  = in_valid && exp_ready;
        take = full && out_ready;
        if (flush) asm_w.delete();
        if (acc) begin
            asm_w.push_back(stored(in_data));
            if (asm_w.size() == 4) begin
                held = {asm_w[0], asm_w[1], asm_w[2], asm_w[3]};
                exp_q.push_back(held);
                nblk++;
                full = 1;
                asm_w.delete();
            end else if (take) begin
                full = 0;
            end
        end else if (take) begin
            full = 0;
        end
    endtask

    task automatic cycle(input bit v, input logic [31:0] d, input bit ordy, input bit fl, output bit acc);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        #2;
        model_step(acc);
    endtask

    task automatic feed(input logic [31:0] d, input bit ordy);
        bit acc;
        int k;
        acc = 0;
        for (k = 0; k < 20 && !acc; k++) cycle(1'b1, d, ordy, 1'b0, acc);
        if (!acc) chk("feed_timeout", 128'd0, 128'd1);
    endtask

    // Monitor: pops the scoreboard whenever the DUT hands over a block.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (rstn && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_block", out_data, 128'hx);
                end else begin
                    chk("sb_block", out_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        bit acc;
        int cyc;
        logic [31:0] fips [4];
        fips[0] = 32'h00112233; fips[1] = 32'h44556677;
        fips[2] = 32'h8899aabb; fips[3] = 32'hccddeeff;

        nblk = 0;
        model_reset();
        rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #12;
        chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("rst_out_data", out_data, 128'd0);
        chk("rst_word_cnt", {126'd0, word_cnt}, 128'd0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("post_rst_in_ready", {127'd0, in_ready}, 128'd1);

        // FIPS-197 plaintext, back-to-back
        for (int i = 0; i < 4; i++) feed(bus_word(fips[i]), 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b0, acc);
        chk("fips_block", out_data, 128'h00112233445566778899aabbccddeeff);
        cycle(1'b0, '0, 1'b1, 1'b0, acc);

        // Backpressure: 8 words, out_ready low
        for (int i = 1; i <= 7; i++) begin
            cycle(1'b1, 32'h1000_0000 * i + i, 1'b0, 1'b0, acc);
            chk("bp_accept", {127'd0, acc}, 128'd1);
        end
        cycle(1'b1, 32'h8000_0008, 1'b0, 1'b0, acc);
        chk("bp_stall", {127'd0, in_ready}, 128'd0);
        chk("bp_cnt3", {126'd0, word_cnt}, 128'd3);
        cycle(1'b1, 32'h8000_0008, 1'b1, 1'b0, acc);
        chk("bp_word8", {127'd0, acc}, 128'd1);
        cycle(1'b0, '0, 1'b1, 1'b0, acc);
        cycle(1'b0, '0, 1'b1, 1'b0, acc);

        // Flush
        feed(32'hAAAAAAAA, 1'b1);
        feed(32'hBBBBBBBB, 1'b1);
        cycle(1'b1, 32'hCCCCCCCC, 1'b1, 1'b1, acc);
        chk("flush_no_accept", {127'd0, in_ready}, 128'd0);
        for (int i = 0; i < 4; i++) feed(32'h11111111, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0, acc);
        chk("flush_block", out_data, {4{32'h11111111}});
        cycle(1'b0, '0, 1'b1, 1'b0, acc);

        // Async reset mid-block with a block pending
        for (int i = 0; i < 6; i++) feed(32'h5000_0000 + i, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("arst_word_cnt", {126'd0, word_cnt}, 128'd0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) feed(bus_word(fips[i]), 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b0, acc);
        chk("arst_fips_block", out_data, 128'h00112233445566778899aabbccddeeff);
        cycle(1'b0, '0, 1'b1, 1'b0, acc);

        // Random throttling, 1000 blocks
        nblk = 0;
        cyc  = 0;
        while (nblk < 1000 && cyc < 30000) begin
            cycle($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 6,
                  $urandom_range(0, 99) < 2, acc);
            cyc++;
        end
        if (nblk < 1000) chk("random_timeout", 128'(nblk), 128'd1000);
        cyc = 0;
        while (full && cyc < 10) begin
            cycle(1'b0, '0, 1'b1, 1'b0, acc);
            cyc++;
        end
        cycle(1'b0, '0, 1'b0, 1'b0, acc);
        chk("sb_drained", 128'(exp_q.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
